// File: rtl/decomp_issue_queue.sv
// Issue queue between the decompressor and the CPU fetch port: accepts one word
// or an atomic pair per cycle, issues one word per cycle, and tracks the head PC.
module decomp_issue_queue #(
  parameter int unsigned            WIDTH     = 32,
  parameter int unsigned            DEPTH     = 4,
  parameter logic [WIDTH-1:0]       PCADD     = 32'b100,
  parameter logic [WIDTH-1:0]       RESET_PC  = 32'h0,
  parameter logic [WIDTH-1:0]       NOP_INSTR = 32'h0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_pair,
  input  logic [WIDTH-1:0]          in_instr0,
  input  logic [WIDTH-1:0]          in_instr1,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          flush_pc,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_instr,
  output logic [WIDTH-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             room;
  logic             push;
  logic             pop;
  logic [CW-1:0]    push_n;
  logic [CW-1:0]    pop_n;

  // Two free slots are demanded even for a single word so a pair never splits.
  always_comb begin
    room      = (cnt <= CW'(DEPTH - 2));
    in_ready  = reset && (state == RUN) && room;
    out_valid = (state == RUN) && (cnt != '0);
    out_instr = out_valid ? mem[rd_ptr] : NOP_INSTR;
    out_pc    = pc_reg;
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
    push_n    = '0;
    if (push) push_n = in_pair ? CW'(2) : CW'(1);
    pop_n     = pop ? CW'(1) : '0;
  end

  assign count = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      pc_reg <= RESET_PC;
    end else if (flush) begin
      state  <= FLUSH;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      pc_reg <= flush_pc;
    end else begin
      state <= RUN;
      if (push) wr_ptr <= wr_ptr + (in_pair ? AW'(2) : AW'(1));
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        pc_reg <= pc_reg + PCADD;
      end
      cnt <= cnt + push_n - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_instr0;
      if (in_pair) mem[wr_ptr + AW'(1)] <= in_instr1;
    end
  end

endmodule

// File: tb/tb_decomp_issue_queue.sv
// Directed self-checking bench for decomp_issue_queue (DEPTH=4, PC step 4).
module tb_decomp_issue_queue;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_pair;
  logic [31:0] in_instr0;
  logic [31:0] in_instr1;
  logic        in_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int unsigned passed;
  int unsigned total;

  decomp_issue_queue #(
    .WIDTH    (32),
    .DEPTH    (4),
    .PCADD    (32'h4),
    .RESET_PC (32'h0),
    .NOP_INSTR(32'h0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_pair  (in_pair),
    .in_instr0(in_instr0),
    .in_instr1(in_instr1),
    .in_ready (in_ready),
    .flush    (flush),
    .flush_pc (flush_pc),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc   (out_pc),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [2:0] cnt);
    chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_count"}, {29'b0, count}, {29'b0, cnt});
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pair   = 1'b0;
    in_instr0 = '0;
    in_instr1 = '0;
    flush     = 1'b0;
    flush_pc  = '0;
    out_ready = 1'b0;
    #1;
    chk_head("rst", 1'b0, 32'h0, 32'h0, 3'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // single pushes, immediate issue
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr0 = 32'hAAAA0001;
    #1;
    chk("pre_push_valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk_head("s1", 1'b1, 32'hAAAA0001, 32'h0, 3'd1);
    in_instr0 = 32'hAAAA0002;
    tick();
    chk_head("s2", 1'b1, 32'hAAAA0002, 32'h4, 3'd1);
    in_valid = 1'b0;
    tick();
    chk_head("s_empty", 1'b0, 32'h0, 32'h8, 3'd0);

    // pair push held, then issued in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pair   = 1'b1;
    in_instr0 = 32'h11;
    in_instr1 = 32'h22;
    tick();
    in_valid = 1'b0;
    in_pair  = 1'b0;
    chk_head("p_held", 1'b1, 32'h11, 32'h8, 3'd2);
    tick();
    chk_head("p_hold2", 1'b1, 32'h11, 32'h8, 3'd2);
    out_ready = 1'b1;
    tick();
    chk_head("p1", 1'b1, 32'h22, 32'hC, 3'd1);
    tick();
    chk_head("p2", 1'b0, 32'h0, 32'h10, 3'd0);

    // fill to three singles; fourth is refused
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr0 = 32'hB1;
    tick();
    chk("f1_ready", {31'b0, in_ready}, 32'd1);
    in_instr0 = 32'hB2;
    tick();
    chk("f2_ready", {31'b0, in_ready}, 32'd1);
    in_instr0 = 32'hB3;
    tick();
    chk("f3_ready", {31'b0, in_ready}, 32'd0);
    chk("f3_count", {29'b0, count}, 32'd3);
    in_instr0 = 32'hB4;
    tick();
    chk_head("f4_ignored", 1'b1, 32'hB1, 32'h10, 3'd3);
    in_valid = 1'b0;

    // drain
    out_ready = 1'b1;
    tick();
    chk_head("d1", 1'b1, 32'hB2, 32'h14, 3'd2);
    tick();
    chk_head("d2", 1'b1, 32'hB3, 32'h18, 3'd1);
    tick();
    chk_head("d3", 1'b0, 32'h0, 32'h1C, 3'd0);

    // streaming push+pop across pointer wrap
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_instr0 = 32'hC0 + 32'(i);
      tick();
      chk_head($sformatf("stream%0d", i), 1'b1, 32'hC0 + 32'(i), 32'h1C + 32'(4 * i), 3'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_head("stream_end", 1'b0, 32'h0, 32'h44, 3'd0);

    // flush beats a simultaneous push and pop
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pair   = 1'b1;
    in_instr0 = 32'hD1;
    in_instr1 = 32'hD2;
    tick();
    chk("fl_pre_count", {29'b0, count}, 32'd2);
    in_pair   = 1'b0;
    in_instr0 = 32'hE1;
    out_ready = 1'b1;
    flush     = 1'b1;
    flush_pc  = 32'h100;
    tick();
    chk_head("fl_bubble", 1'b0, 32'h0, 32'h100, 3'd0);
    chk("fl_bubble_ready", {31'b0, in_ready}, 32'd0);
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_head("fl_run", 1'b0, 32'h0, 32'h100, 3'd0);
    chk("fl_run_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk_head("fl_first", 1'b1, 32'hE1, 32'h100, 3'd1);

    // asynchronous reset with three entries queued
    in_instr0 = 32'hE2;
    tick();
    in_instr0 = 32'hE3;
    tick();
    in_valid = 1'b0;
    chk("ar_pre_count", {29'b0, count}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk_head("ar", 1'b0, 32'h0, 32'h0, 3'd0);
    chk("ar_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("ar_rel_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr0 = 32'hF1;
    tick();
    in_valid = 1'b0;
    chk_head("ar_fresh", 1'b1, 32'hF1, 32'h0, 3'd1);
    tick();
    chk_head("ar_drain", 1'b0, 32'h0, 32'h4, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
